// File: rtl/remote_cmd_tx.sv
// -----------------------------------------------------------------------------
// remote_cmd_tx
//
// Host-side end of the command link. A 16-bit command is sent as two UART
// frames (high byte first) on TX. The one-byte acknowledge that comes back on
// RX is captured and held for the host. Both UART engines are built in.
//
// Parameters:
//   BAUD_DIV     clk cycles per UART bit (16..4095)
//   TIMEOUT_CYC  response-wait limit in clk cycles (used with RESP_TIMEOUT_EN)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   cmd[15:0]     command word, captured when snd_cmd is accepted
//   snd_cmd       one-cycle send request (ignored while busy)
//   busy          high from the cycle after acceptance until cmd_snt
//   cmd_snt       one-cycle pulse when the low byte's stop bit completes
//   TX            UART serial out, idles high
//   RX            UART serial in, asynchronous to clk
//   resp[7:0]     last valid response byte
//   resp_rdy      response valid, held until cleared
//   clr_resp_rdy  clears resp_rdy
//   resp_timeout  one-cycle pulse when no response arrives in time
//
// Optional feature (compile-time macro RESP_TIMEOUT_EN):
//   Defined   - a 23-bit counter started by cmd_snt raises resp_timeout if no
//               valid response or new command arrives within TIMEOUT_CYC.
//   Undefined - resp_timeout is tied low and no counter exists.
// -----------------------------------------------------------------------------
module remote_cmd_tx #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        busy,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy,
    output logic        resp_timeout
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    // The falling edge is detected in cycle 0 and the counter reads 0 one
    // cycle later, so comparing against half-1 samples BAUD_DIV/2 cycles
    // after the detected edge.
    localparam logic [11:0] BAUD_MID  = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [11:0] r_tx_baud,  w_tx_baud_nxt;
    logic [3:0]  r_tx_bit,   w_tx_bit_nxt;   // 0 start, 1..8 data, 9 stop
    logic        r_tx,       w_tx_nxt;
    logic [15:0] r_cmd;
    logic [7:0]  w_tx_byte;
    logic        w_accept;

    assign w_tx_byte = (r_tx_state == HI) ? r_cmd[15:8] : r_cmd[7:0];

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_baud_nxt  = r_tx_baud;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_nxt       = r_tx;
        w_accept       = 1'b0;
        case (r_tx_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (snd_cmd) begin
                    // Start bit leaves on the same edge that accepts the command.
                    w_accept       = 1'b1;
                    w_tx_state_nxt = HI;
                    w_tx_baud_nxt  = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_nxt       = 1'b0;
                end
            end
            HI, LO: begin
                if (r_tx_baud == BAUD_LAST) begin
                    w_tx_baud_nxt = '0;
                    if (r_tx_bit == 4'd9) begin
                        w_tx_bit_nxt = '0;
                        if (r_tx_state == HI) begin
                            // Low byte's start bit follows the high stop bit directly.
                            w_tx_state_nxt = LO;
                            w_tx_nxt       = 1'b0;
                        end else begin
                            w_tx_state_nxt = DONE;
                            w_tx_nxt       = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 4'd1;
                        // Moving to bit r_tx_bit+1: data bit index is r_tx_bit.
                        w_tx_nxt = (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
                    end
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 12'd1;
                end
            end
            DONE: begin
                w_tx_state_nxt = IDLE;
                w_tx_nxt       = 1'b1;
            end
            default: begin
                w_tx_state_nxt = IDLE;
                w_tx_nxt       = 1'b1;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;   // asynchronous set: line goes idle at once
            r_cmd      <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_baud  <= w_tx_baud_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx       <= w_tx_nxt;
            if (w_accept) begin
                r_cmd <= cmd;
            end
        end
    end

    assign TX      = r_tx;
    assign busy    = (r_tx_state == HI) || (r_tx_state == LO);
    assign cmd_snt = (r_tx_state == DONE);

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic        w_rx_fall;
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [11:0] r_rx_baud,  w_rx_baud_nxt;
    logic [3:0]  r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        w_rx_valid;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_baud_nxt  = r_rx_baud;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_valid     = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nxt = R_START;
                    w_rx_baud_nxt  = '0;
                end
            end
            R_START: begin
                if (r_rx_baud == BAUD_MID) begin
                    w_rx_baud_nxt = '0;
                    w_rx_bit_nxt  = '0;
                    // High at mid-start means a glitch: drop it silently.
                    w_rx_state_nxt = r_rx_sync ? R_IDLE : R_DATA;
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 12'd1;
                end
            end
            R_DATA: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_baud_nxt  = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 4'd7) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = R_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 4'd1;
                    end
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 12'd1;
                end
            end
            R_STOP: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_baud_nxt  = '0;
                    w_rx_state_nxt = R_IDLE;
                    w_rx_valid     = r_rx_sync;   // low stop bit: framing error
                end else begin
                    w_rx_baud_nxt = r_rx_baud + 12'd1;
                end
            end
            default: w_rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= R_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_resp     <= '0;
            r_resp_rdy <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_baud  <= w_rx_baud_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            if (w_rx_valid) begin
                r_resp <= r_rx_shift;
            end
            // A new byte wins over a simultaneous clear.
            if (w_rx_valid) begin
                r_resp_rdy <= 1'b1;
            end else if (clr_resp_rdy || w_accept) begin
                r_resp_rdy <= 1'b0;
            end
        end
    end

    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;

    // ------------------------------------------------------------------
    // Response timeout
    // ------------------------------------------------------------------
`ifdef RESP_TIMEOUT_EN
    localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYC - 1);

    logic [22:0] r_to_cnt;
    logic        r_to_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_to_run <= 1'b0;
        end else if (cmd_snt) begin
            r_to_cnt <= '0;
            r_to_run <= 1'b1;
        end else if (w_rx_valid || w_accept || resp_timeout) begin
            r_to_run <= 1'b0;
        end else if (r_to_run) begin
            r_to_cnt <= r_to_cnt + 23'd1;
        end
    end

    assign resp_timeout = r_to_run && (r_to_cnt == TO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign resp_timeout     = 1'b0;
`endif

endmodule
